// File: rtl/axi_lite_master_arbiter.sv
// Round-robin arbiter and single-beat sequencer sharing one AXI-lite master among NUM_REQ requesters.
// Latency: write 3 cycles, read 4 cycles from req_ready to resp_valid inclusive with a zero-wait slave.
// Backpressure: one transaction in flight; other requesters wait unacknowledged; VALIDs hold until handshake.
module axi_lite_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            awaddr,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH/8-1:0]          wstrb,
    output logic                             wvalid,
    input  logic                             wready,
    output logic [ADDR_WIDTH-1:0]            araddr,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic                             rvalid,
    output logic                             rready
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD_A, ST_RD_D, ST_RESP} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, gnt_q, gnt_idx, cand_idx, rr_ptr_nxt;
    logic                 gnt_found;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic                 aw_done_q, w_done_q;
    logic                 aw_hs, w_hs;

    // First pending requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        rr_ptr_nxt = IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A grant during reset would be lost, so hold off acknowledging it.
                if (gnt_found && !ARESET) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_d = req_write[gnt_idx] ? ST_WR : ST_RD_A;
                end
            end
            ST_WR: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                aw_hs   = awvalid && awready;
                w_hs    = wvalid && wready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                    state_d = ST_RESP;
            end
            ST_RD_A: begin
                arvalid = 1'b1;
                if (arready)
                    state_d = ST_RD_D;
            end
            ST_RD_D: begin
                rready = 1'b1;
                if (rvalid)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[gnt_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign awaddr     = awvalid ? addr_q  : '0;
    assign wdata      = wvalid  ? wdata_q : '0;
    assign wstrb      = wvalid  ? wstrb_q : '0;
    assign araddr     = arvalid ? addr_q  : '0;
    assign resp_rdata = rdata_q;
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        gnt_q     <= gnt_idx;
                        rr_ptr_q  <= rr_ptr_nxt;
                        addr_q    <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q   <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_q   <= req_wstrb[int'(gnt_idx)*STRB_W +: STRB_W];
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (aw_hs)
                        aw_done_q <= 1'b1;
                    if (w_hs)
                        w_done_q <= 1'b1;
                    // Writes return zero read data.
                    if (state_d == ST_RESP)
                        rdata_q <= '0;
                end
                ST_RD_D: begin
                    if (rvalid)
                        rdata_q <= rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter: reset, round-robin order, table of
// single transactions with slave wait states, and reset during the read-data phase.
module tb_axi_lite_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [N-1:0]      req_valid, req_write, req_ready, resp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*DW/8-1:0] req_wstrb;
    logic [DW-1:0]     resp_rdata;
    logic              busy;
    logic [AW-1:0]     awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        wr;
        int          rq;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        int          aw_d, w_d, ar_d, r_d;
        logic [31:0] rd;
        int          lat;     // cycles from req_ready to resp_valid
        int          n_aw, n_w, n_ar;
    } txn_t;

    txn_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*4 +: 4] = s;
    endtask

    task automatic run_txn(input txn_t t);
        int accepted = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
        logic [31:0] exp_rd;
        exp_rd = t.wr ? 32'h0 : t.rd;
        @(negedge ACLK);
        set_req(t.rq, t.wr, t.addr, t.wd, t.st);
        req_valid = onehot(t.rq);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge ACLK);
            if (accepted != 0) req_valid = '0;
            awready = awvalid && (aw_cnt >= t.aw_d);
            wready  = wvalid && (w_cnt >= t.w_d);
            arready = arvalid && (ar_cnt >= t.ar_d);
            rvalid  = rready && (r_cnt >= t.r_d);
            rdata   = rvalid ? t.rd : 32'hBAD0_BAD0;
            #1;
            if (req_ready != '0) begin
                chk("txn_grant", req_ready, onehot(t.rq));
                chk("txn_single_ready", accepted, 0);
                accepted = 1;
                acc_cyc = cyc;
            end
            if (awvalid) begin
                chk("txn_awaddr", awaddr, t.addr);
                aw_cnt++;
            end
            if (wvalid) begin
                chk("txn_wdata", {wstrb, wdata}, {t.st, t.wd});
                w_cnt++;
            end
            if (arvalid) begin
                chk("txn_araddr", araddr, t.addr);
                ar_cnt++;
            end
            if (rready) r_cnt++;
            if (resp_valid != '0) begin
                chk("txn_resp_onehot", resp_valid, onehot(t.rq));
                chk("txn_resp_rdata", resp_rdata, exp_rd);
                resp_cnt++;
                resp_cyc = cyc;
            end else if (resp_cnt > 0) begin
                chk("txn_rdata_hold", resp_rdata, exp_rd);
                if (cyc >= resp_cyc + 2) break;
            end
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;
        chk("txn_accepted", accepted, 1);
        chk("txn_resp_count", resp_cnt, 1);
        chk("txn_latency", resp_cyc - acc_cyc, t.lat);
        chk("txn_aw_cycles", aw_cnt, t.n_aw);
        chk("txn_w_cycles", w_cnt, t.n_w);
        chk("txn_ar_cycles", ar_cnt, t.n_ar);
        chk("txn_idle_after", busy, 0);
    endtask

    initial begin
        int exp_g, grants, last_g, resps, waited;

        //         wr    rq addr          wdata          st    awd wd ard rd rdata          lat naw nw nar
        tbl[0] = '{1'b1, 0, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 32'h0,         2,  1, 1, 0};
        tbl[1] = '{1'b0, 2, 32'h20,       32'h0,        4'h0, 0, 0, 3, 2, 32'h12345678,  8,  0, 0, 4};
        tbl[2] = '{1'b1, 1, 32'h44,       32'hA5A5A5A5, 4'h3, 3, 0, 0, 0, 32'h0,         5,  4, 1, 0};
        tbl[3] = '{1'b1, 3, 32'hFFFFFFFC, 32'h01020304, 4'h8, 0, 2, 0, 0, 32'h0,         4,  1, 3, 0};
        tbl[4] = '{1'b0, 0, 32'h8,        32'h0,        4'h0, 0, 0, 0, 0, 32'hCAFEF00D,  3,  0, 0, 1};
        tbl[5] = '{1'b1, 2, 32'h100,      32'h55AA55AA, 4'hC, 2, 2, 0, 0, 32'h0,         4,  3, 3, 0};
        tbl[6] = '{1'b0, 3, 32'h7FFFFFF0, 32'h0,        4'h0, 0, 0, 1, 4, 32'h80000001,  8,  0, 0, 2};

        ARESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;

        // Reset state, with all requesters already pending.
        repeat (3) @(negedge ACLK);
        for (int i = 0; i < N; i++) set_req(i, (i % 2) == 0, 32'h1000 + i, 32'h0, 4'hF);
        req_valid = 4'hF;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, rready}, 0);
        chk("rst_addrs", {awaddr, araddr}, 0);
        chk("rst_wdata", {wstrb, wdata}, 0);
        chk("rst_resp_rdata", resp_rdata, 0);

        // Round-robin with every requester held, zero-wait slave.
        awready = 1'b1; wready = 1'b1; arready = 1'b1; rvalid = 1'b1; rdata = 32'h11112222;
        exp_g = 0; grants = 0; last_g = 0; resps = 0;
        for (int c = 0; c < 80 && grants < 5; c++) begin
            @(negedge ACLK);
            if (c == 0) ARESET = 1'b0;
            #1;
            if (req_ready != '0) begin
                chk("rr_grant", req_ready, onehot(exp_g));
                last_g = exp_g;
                exp_g = (exp_g + 1) % N;
                grants++;
            end
            if (resp_valid != '0) begin
                chk("rr_resp", resp_valid, onehot(last_g));
                resps++;
            end
        end
        chk("rr_grants", grants, 5);
        chk("rr_resps", resps, 4);
        @(negedge ACLK);
        req_valid = '0;
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge ACLK);
            #1;
            waited++;
        end
        chk("rr_drain", busy, 0);
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset during the read-data phase aborts the read and restarts the pointer.
        @(negedge ACLK);
        set_req(1, 1'b0, 32'h30, 32'h0, 4'h0);
        req_valid = 4'b0010;
        arready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            #1;
            if (busy) req_valid = '0;
            if (rready) break;
        end
        chk("abort_reach_rd_d", rready, 1);
        @(negedge ACLK);
        ARESET = 1'b1;
        arready = 1'b0;
        @(negedge ACLK);
        #1;
        chk("abort_rready", rready, 0);
        chk("abort_arvalid", arvalid, 0);
        chk("abort_busy", busy, 0);
        ARESET = 1'b0;
        resps = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            #1;
            if (resp_valid != '0) resps++;
        end
        chk("abort_no_resp", resps, 0);
        @(negedge ACLK);
        set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h4C, 32'h0, 4'h0);
        req_valid = 4'b1001;
        #1;
        chk("abort_next_grant", req_ready, 4'b0001);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BADF00D;
        @(negedge ACLK);
        req_valid = '0;
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge ACLK);
            #1;
            waited++;
        end
        chk("abort_final_idle", busy, 0);
        chk("abort_final_rdata", resp_rdata, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
